// File: rtl/mskaes_32bits_state_fsm.sv
// -----------------------------------------------------------------------------
// mskaes_32bits_state_fsm
//
// Control sequencer for the masked 32-bit AES state datapath. A start
// handshake latches the direction and loads the shared plaintext. The block
// then steps through 10 rounds and a final key-addition pass, and holds the
// result until the consumer takes it.
//
// Each round is split into an issue phase (4 columns presented to the Sbox),
// an optional wait phase covering the extra Sbox latency, and a writeback
// phase (4 columns written back as the Sbox results emerge).
//
// Parameters:
//   SBOX_LAT             Sbox pipeline latency in cycles (4..15)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    start handshake; in_inverse selects decrypt
//   out_valid/out_ready  result handshake; result held in datapath state
//   busy                 operation in progress (LOAD through FINAL)
//   dp_*                 datapath enable, load and routing selects
//   sbox_in_valid        a column is presented to the Sbox this cycle
//   key_col_req          key schedule must present a round-key column
//   round_idx            0 in LOAD, 1..10 in rounds, 11 in FINAL
//   col_idx              column index within the issue/writeback phase
//
// Every output is decoded from registered state only, so no combinational
// path exists from in_valid or out_ready to any output.
// -----------------------------------------------------------------------------
module mskaes_32bits_state_fsm #(
   parameter int SBOX_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_inverse,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       dp_enable,
   output logic       dp_init,
   output logic       dp_en_MC,
   output logic       dp_en_loop,
   output logic       dp_en_loop_r0,
   output logic       dp_en_SB_inverse,
   output logic       dp_bypass_MC_inverse,
   output logic       dp_en_toSB_inverse,
   output logic       sbox_in_valid,
   output logic       key_col_req,
   output logic [3:0] round_idx,
   output logic [1:0] col_idx
);

   generate
      if (SBOX_LAT < 4 || SBOX_LAT > 15) begin : g_bad_sbox_lat
         $error("mskaes_32bits_state_fsm: SBOX_LAT must be in the range 4..15");
      end
   endgenerate

   // Last phase of a round and the first writeback phase.
   localparam logic [4:0] PH_LAST = 5'(SBOX_LAT + 3);
   localparam logic [4:0] PH_WB   = 5'(SBOX_LAT);
   // Writeback column = p - SBOX_LAT; only the low two bits matter.
   localparam logic [1:0] LAT_LO  = 2'(SBOX_LAT % 4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_t;

   state_t     r_state;
   logic       r_inv;
   logic [3:0] r_round;
   logic [4:0] r_phase;
   logic [1:0] r_fcnt;

   state_t     w_state_nxt;
   logic       w_inv_nxt;
   logic [3:0] w_round_nxt;
   logic [4:0] w_phase_nxt;
   logic [1:0] w_fcnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_inv   <= 1'b0;
         r_round <= 4'd0;
         r_phase <= 5'd0;
         r_fcnt  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_inv   <= w_inv_nxt;
         r_round <= w_round_nxt;
         r_phase <= w_phase_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt          = r_state;
      w_inv_nxt            = r_inv;
      w_round_nxt          = r_round;
      w_phase_nxt          = r_phase;
      w_fcnt_nxt           = r_fcnt;

      in_ready             = 1'b0;
      out_valid            = 1'b0;
      busy                 = 1'b0;
      dp_enable            = 1'b0;
      dp_init              = 1'b0;
      dp_en_MC             = 1'b0;
      dp_en_loop           = 1'b0;
      dp_en_loop_r0        = 1'b0;
      dp_en_SB_inverse     = 1'b0;
      dp_bypass_MC_inverse = 1'b0;
      dp_en_toSB_inverse   = 1'b0;
      sbox_in_valid        = 1'b0;
      key_col_req          = 1'b0;
      round_idx            = 4'd0;
      col_idx              = 2'd0;

      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = S_LOAD;
               w_inv_nxt   = in_inverse;
            end
         end

         S_LOAD: begin
            busy        = 1'b1;
            dp_enable   = 1'b1;
            dp_init     = 1'b1;
            w_state_nxt = S_ROUND;
            w_round_nxt = 4'd1;
            w_phase_nxt = 5'd0;
         end

         S_ROUND: begin
            busy      = 1'b1;
            round_idx = r_round;
            if (r_phase < 5'd4) begin
               // Issue: present column p to the Sbox with its key column.
               dp_enable            = 1'b1;
               sbox_in_valid        = 1'b1;
               key_col_req          = 1'b1;
               col_idx              = r_phase[1:0];
               dp_en_loop_r0        = 1'b1;
               dp_en_loop           = r_inv;
               dp_en_toSB_inverse   = r_inv;
               // Decrypt round 1 has no InvMixColumns ahead of the Sbox.
               dp_bypass_MC_inverse = r_inv && (r_round == 4'd1);
            end else if (r_phase >= PH_WB) begin
               // Writeback: Sbox results for columns 0..3 emerge now.
               dp_enable        = 1'b1;
               col_idx          = r_phase[1:0] - LAT_LO;
               // The last encrypt round skips MixColumns.
               dp_en_MC         = !r_inv && (r_round != 4'd10);
               dp_en_SB_inverse = r_inv;
            end

            if (r_phase == PH_LAST) begin
               w_phase_nxt = 5'd0;
               if (r_round == 4'd10) begin
                  w_state_nxt = S_FINAL;
                  w_fcnt_nxt  = 2'd0;
               end else begin
                  w_round_nxt = r_round + 4'd1;
               end
            end else begin
               w_phase_nxt = r_phase + 5'd1;
            end
         end

         S_FINAL: begin
            // Closing key addition over the 4 columns, no Sbox traffic.
            busy                 = 1'b1;
            round_idx            = 4'd11;
            col_idx              = r_fcnt;
            dp_enable            = 1'b1;
            dp_en_loop_r0        = 1'b1;
            dp_en_loop           = r_inv;
            key_col_req          = 1'b1;
            dp_bypass_MC_inverse = 1'b1;
            w_fcnt_nxt           = r_fcnt + 2'd1;
            if (r_fcnt == 2'd3) begin
               w_state_nxt = S_DONE;
            end
         end

         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mskaes_32bits_state_fsm.sv
module tb_mskaes_32bits_state_fsm;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // SBOX_LAT = 4 instance
   logic iv4 = 1'b0, inv4 = 1'b0, ordy4 = 1'b0;
   logic ir4, ov4, bz4, en4, in4, mc4, lp4, r04, sb4, bp4, ts4, sv4, kr4;
   logic [3:0] rnd4;
   logic [1:0] col4;

   // SBOX_LAT = 7 instance
   logic iv7 = 1'b0, inv7 = 1'b0, ordy7 = 1'b0;
   logic ir7, ov7, bz7, en7, in7, mc7, lp7, r07, sb7, bp7, ts7, sv7, kr7;
   logic [3:0] rnd7;
   logic [1:0] col7;

   mskaes_32bits_state_fsm #(.SBOX_LAT(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(iv4), .in_ready(ir4), .in_inverse(inv4),
      .out_valid(ov4), .out_ready(ordy4), .busy(bz4),
      .dp_enable(en4), .dp_init(in4), .dp_en_MC(mc4), .dp_en_loop(lp4),
      .dp_en_loop_r0(r04), .dp_en_SB_inverse(sb4),
      .dp_bypass_MC_inverse(bp4), .dp_en_toSB_inverse(ts4),
      .sbox_in_valid(sv4), .key_col_req(kr4),
      .round_idx(rnd4), .col_idx(col4)
   );

   mskaes_32bits_state_fsm #(.SBOX_LAT(7)) dut7 (
      .clk(clk), .rst(rst),
      .in_valid(iv7), .in_ready(ir7), .in_inverse(inv7),
      .out_valid(ov7), .out_ready(ordy7), .busy(bz7),
      .dp_enable(en7), .dp_init(in7), .dp_en_MC(mc7), .dp_en_loop(lp7),
      .dp_en_loop_r0(r07), .dp_en_SB_inverse(sb7),
      .dp_bypass_MC_inverse(bp7), .dp_en_toSB_inverse(ts7),
      .sbox_in_valid(sv7), .key_col_req(kr7),
      .round_idx(rnd7), .col_idx(col7)
   );

   // Flag order: in_ready out_valid busy enable init MC loop loop_r0
   //             SB_inverse bypass_MC_inverse toSB_inverse sbox_valid key_req
   localparam logic [12:0] F_IDLE    = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] F_LOAD    = 13'b0_0_1_1_1_0_0_0_0_0_0_0_0;
   localparam logic [12:0] F_EISS    = 13'b0_0_1_1_0_0_0_1_0_0_0_1_1;
   localparam logic [12:0] F_EWB     = 13'b0_0_1_1_0_1_0_0_0_0_0_0_0;
   localparam logic [12:0] F_EWB10   = 13'b0_0_1_1_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] F_EFIN    = 13'b0_0_1_1_0_0_0_1_0_1_0_0_1;
   localparam logic [12:0] F_DONE    = 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] F_DISS1   = 13'b0_0_1_1_0_0_1_1_0_1_1_1_1;
   localparam logic [12:0] F_DISS    = 13'b0_0_1_1_0_0_1_1_0_0_1_1_1;
   localparam logic [12:0] F_DWB     = 13'b0_0_1_1_0_0_0_0_1_0_0_0_0;
   localparam logic [12:0] F_DFIN    = 13'b0_0_1_1_0_0_1_1_0_1_0_0_1;
   localparam logic [12:0] F_WAIT    = 13'b0_0_1_0_0_0_0_0_0_0_0_0_0;

   typedef struct {
      int          slot;
      int          off;
      logic [18:0] exp;
   } vec_t;

   vec_t        vt[$];
   logic [18:0] trace [4][120];
   int          n_vec = 0;
   int          n_bad = 0;

   function automatic logic [18:0] w(input logic [12:0] f, input int rnd, input int col);
      return {f, 4'(rnd), 2'(col)};
   endfunction

   function automatic logic [18:0] pack(input logic s7);
      if (s7)
         return {ir7, ov7, bz7, en7, in7, mc7, lp7, r07, sb7, bp7, ts7, sv7, kr7, rnd7, col7};
      return {ir4, ov4, bz4, en4, in4, mc4, lp4, r04, sb4, bp4, ts4, sv4, kr4, rnd4, col4};
   endfunction

   function automatic void add(input int slot, input int off, input logic [18:0] exp);
      vec_t v;
      v.slot = slot; v.off = off; v.exp = exp;
      vt.push_back(v);
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Call just after a rising edge with the selected instance in IDLE.
   // Offset 0 is the handshake cycle; direction flips and a spurious start
   // request are injected mid-operation.
   task automatic run_op(input int slot, input logic inv, input int n);
      logic s7;
      s7 = (slot == 2);
      if (s7) begin iv7 = 1'b1; inv7 = inv; end
      else    begin iv4 = 1'b1; inv4 = inv; end
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         trace[slot][k] = pack(s7);
         @(posedge clk); #1;
         if (k == 0) begin
            iv4 = 1'b0; iv7 = 1'b0; inv4 = ~inv; inv7 = ~inv;
         end
         if (k == 20) begin
            if (s7) iv7 = 1'b1; else iv4 = 1'b1;
         end
         if (k == 23) begin
            iv4 = 1'b0; iv7 = 1'b0;
         end
      end
   endtask

   task automatic release_done(input logic s7);
      if (s7) ordy7 = 1'b1; else ordy4 = 1'b1;
      @(posedge clk); #1;
      ordy4 = 1'b0; ordy7 = 1'b0;
   endtask

   function automatic int count_bit(input int slot, input int bitn, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (trace[slot][k][bitn]) c++;
      return c;
   endfunction

   function automatic int count_wait(input int slot, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (trace[slot][k][16] && !trace[slot][k][15]) c++;
      return c;
   endfunction

   initial begin
      // slot 0: encrypt, SBOX_LAT=4
      add(0, 0,  w(F_IDLE, 0, 0));
      add(0, 1,  w(F_LOAD, 0, 0));
      add(0, 2,  w(F_EISS, 1, 0));
      add(0, 5,  w(F_EISS, 1, 3));
      add(0, 6,  w(F_EWB, 1, 0));
      add(0, 9,  w(F_EWB, 1, 3));
      add(0, 10, w(F_EISS, 2, 0));
      add(0, 74, w(F_EISS, 10, 0));
      add(0, 78, w(F_EWB10, 10, 0));
      add(0, 81, w(F_EWB10, 10, 3));
      add(0, 82, w(F_EFIN, 11, 0));
      add(0, 85, w(F_EFIN, 11, 3));
      add(0, 86, w(F_DONE, 0, 0));
      // slot 1: decrypt, SBOX_LAT=4
      add(1, 1,  w(F_LOAD, 0, 0));
      add(1, 2,  w(F_DISS1, 1, 0));
      add(1, 5,  w(F_DISS1, 1, 3));
      add(1, 6,  w(F_DWB, 1, 0));
      add(1, 10, w(F_DISS, 2, 0));
      add(1, 78, w(F_DWB, 10, 0));
      add(1, 82, w(F_DFIN, 11, 0));
      add(1, 85, w(F_DFIN, 11, 3));
      add(1, 86, w(F_DONE, 0, 0));
      // slot 2: encrypt, SBOX_LAT=7
      add(2, 2,   w(F_EISS, 1, 0));
      add(2, 6,   w(F_WAIT, 1, 0));
      add(2, 8,   w(F_WAIT, 1, 0));
      add(2, 9,   w(F_EWB, 1, 0));
      add(2, 12,  w(F_EWB, 1, 3));
      add(2, 13,  w(F_EISS, 2, 0));
      add(2, 108, w(F_EWB10, 10, 0));
      add(2, 111, w(F_EWB10, 10, 3));
      add(2, 112, w(F_EFIN, 11, 0));
      add(2, 115, w(F_EFIN, 11, 3));
      add(2, 116, w(F_DONE, 0, 0));
      // slot 3: run after a mid-operation reset
      add(3, 1,  w(F_LOAD, 0, 0));
      add(3, 2,  w(F_EISS, 1, 0));
      add(3, 86, w(F_DONE, 0, 0));

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset4", pack(1'b0), w(F_IDLE, 0, 0));
      check("reset7", pack(1'b1), w(F_IDLE, 0, 0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Encrypt, then hold in DONE with out_ready low and a start request
      run_op(0, 1'b0, 87);
      iv4 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("done_hold", pack(1'b0), w(F_DONE, 0, 0));
         @(posedge clk); #1;
      end
      iv4 = 1'b0;
      ordy4 = 1'b1;
      @(negedge clk);
      check("done_accept", pack(1'b0), w(F_DONE, 0, 0));
      @(posedge clk); #1;
      ordy4 = 1'b0;
      @(negedge clk);
      check("idle_after_done", pack(1'b0), w(F_IDLE, 0, 0));
      @(posedge clk); #1;

      run_op(1, 1'b1, 87);
      release_done(1'b0);

      run_op(2, 1'b0, 117);
      release_done(1'b1);

      // Reset in round 5, phase 2 (offset 2 + 4*8 + 2 = 36)
      iv4 = 1'b1; inv4 = 1'b0;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         @(posedge clk); #1;
         if (k == 0) iv4 = 1'b0;
      end
      @(negedge clk);
      check("r5_p2", pack(1'b0), w(F_EISS, 5, 2));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_op", pack(1'b0), w(F_IDLE, 0, 0));
      @(posedge clk); #1;
      run_op(3, 1'b0, 87);
      release_done(1'b0);

      // Table of per-cycle expectations
      foreach (vt[i]) begin
         check($sformatf("slot%0d_off%0d", vt[i].slot, vt[i].off),
               trace[vt[i].slot][vt[i].off], vt[i].exp);
      end

      // Aggregate counts over whole operations (offsets 0..end)
      check_int("enc_key_req",   count_bit(0, 6, 87), 44);
      check_int("enc_mc",        count_bit(0, 13, 87), 36);
      check_int("enc_sbox_vld",  count_bit(0, 7, 87), 40);
      check_int("dec_mc",        count_bit(1, 13, 87), 0);
      check_int("dec_bypass",    count_bit(1, 9, 87), 8);
      check_int("dec_toSB",      count_bit(1, 8, 87), 40);
      check_int("dec_SB_inv",    count_bit(1, 10, 87), 40);
      check_int("lat7_wait",     count_wait(2, 117), 30);
      check_int("lat7_key_req",  count_bit(2, 6, 117), 44);
      check_int("lat7_out_vld",  count_bit(2, 17, 117), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mskaes_32bits_state_fsm.md
Name: mskaes_32bits_state_fsm

Overview:
Control sequencer for the masked 32-bit AES state datapath. It accepts a start handshake with a direction flag and loads the shared plaintext. It then drives the datapath's routing selects and enable through 10 rounds, with column issue and writeback phases timed against the Sbox pipeline latency. It ends with a final key-addition pass and holds the result until it is consumed. It sits between the top-level core handshake and the state datapath, and also issues round and column strobes to the key schedule.

Parameters:
SBOX_LAT, 4, pipeline latency in cycles from a column presented to the Sbox to its result; legal values are 4 to 15. Elaboration must fail outside this range.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  start request; plaintext shares are valid on the datapath input
in_ready  out  1  block can accept a start request
in_inverse  in  1  direction, sampled at the handshake: 0 = encrypt, 1 = decrypt
out_valid  out  1  result held in the datapath state register
out_ready  in  1  consumer accepts the result
busy  out  1  operation in progress (LOAD through FINAL)
dp_enable  out  1  state register enable
dp_init  out  1  load plaintext into the state register
dp_en_MC  out  1  writeback uses the MixColumns output
dp_en_loop  out  1  rows 1-3 take the inverse key-added feedback path
dp_en_loop_r0  out  1  row 0 takes the key-added feedback path
dp_en_SB_inverse  out  1  rows 1-3 take the Sbox output on the inverse path
dp_bypass_MC_inverse  out  1  bypass InvMixColumns
dp_en_toSB_inverse  out  1  Sbox input is taken from the inverse path
sbox_in_valid  out  1  a column is presented to the Sbox this cycle
key_col_req  out  1  key schedule must present the round-key column this cycle
round_idx  out  4  current round: 0 in LOAD, 1-10 in rounds, 11 in FINAL
col_idx  out  2  column index within the current issue or writeback phase

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, all dp_* outputs 0, sbox_in_valid 0, key_col_req 0, out_valid 0, busy 0, round_idx 0, col_idx 0, in_ready 1.
- rst is honoured in any state: an operation in progress is abandoned, with no out_valid and no stray enable in the following cycle.
- All dp_*, strobe and index outputs are registered, or decoded only from registered state and counters. No combinational path exists from in_valid or out_ready to any dp_* output.
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - in_ready is 1.
  - When in_valid is 1, the block latches in_inverse into inv_q and moves to LOAD.
- LOAD: one cycle with dp_init=1 and dp_enable=1; round_idx=0. Next state is ROUND, round 1, phase 0.
- ROUND: phase counter p runs 0 to SBOX_LAT+3, so each round lasts SBOX_LAT+4 cycles.
- Issue phase, p=0..3:
  - dp_enable=1, sbox_in_valid=1, key_col_req=1, col_idx=p.
  - dp_en_loop_r0=1, dp_en_loop=inv_q, dp_en_toSB_inverse=inv_q.
  - dp_bypass_MC_inverse = inv_q AND (round==1).
- Wait phase, p=4..SBOX_LAT-1: dp_enable=0 and all selects 0. This phase is empty when SBOX_LAT=4.
- Writeback phase, p=SBOX_LAT..SBOX_LAT+3:
  - dp_enable=1, col_idx = p-SBOX_LAT.
  - dp_en_loop_r0=0, dp_en_loop=0.
  - dp_en_MC = NOT inv_q AND (round!=10).
  - dp_en_SB_inverse=inv_q.
- Round advance: at p=SBOX_LAT+3 the round increments; after round 10 the state moves to FINAL.
- FINAL: 4 cycles, round_idx=11, col_idx=0..3.
  - dp_enable=1, dp_en_loop_r0=1, dp_en_loop=inv_q, key_col_req=1.
  - sbox_in_valid=0, dp_bypass_MC_inverse=1.
  - Next state is DONE.
- DONE:
  - out_valid=1 and dp_enable=0, so the state is held.
  - in_ready=0.
  - When out_ready is 1, the block returns to IDLE; out_valid deasserts in the next cycle.
  - Back-to-back: in_ready is asserted only in IDLE, so there is a minimum of 1 cycle between out_valid falling and a new LOAD.
- Latency: handshake at cycle T gives LOAD at T+1, rounds at T+2 to T+1+10*(SBOX_LAT+4), FINAL for 4 cycles, and out_valid at T+6+10*(SBOX_LAT+4). For SBOX_LAT=4, out_valid is first high at T+86.
- in_valid while busy is ignored; no request is queued.
- Direction is fixed by inv_q for the whole operation; in_inverse changes mid-operation have no effect.

Test Plan:
- Reset, then encrypt start at T with SBOX_LAT=4 -> LOAD at T+1 with dp_init=1; sbox_in_valid high at T+2..T+5; writeback at T+6..T+9 with dp_en_MC=1; out_valid first at T+86.
- Encrypt round 10 -> dp_en_MC=0 in all 4 writeback cycles; 44 key_col_req pulses in total (40 round, 4 FINAL).
- Decrypt start -> dp_en_toSB_inverse=1 during issue; dp_bypass_MC_inverse=1 only in round 1 issue and FINAL; dp_en_SB_inverse=1 in writeback; dp_en_MC never 1.
- SBOX_LAT=7 -> 3 wait cycles per round with dp_enable=0; out_valid at T+116.
- out_ready held 0 for 20 cycles in DONE -> out_valid and dp_enable=0 stable; in_valid ignored. out_ready=1 -> IDLE next cycle and in_ready=1.
- rst asserted at round 5, p=2 -> the next cycle has all outputs at their reset values and in_ready=1; a new start then completes normally.
